// File: rtl/spd_info_frame_receiver.sv
// Parses HB0..PB27 packet bytes; publishes SPD InfoFrame fields from checksum-clean frames only.
// Latency: outputs and pulses register one cycle after PB27 is accepted.
// Backpressure: none; in_valid low stalls parsing, a long enough gap aborts the packet.
module spd_info_frame_receiver #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk_pixel,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic         in_start,
    input  logic [7:0]   in_byte,
    output logic [63:0]  vendor_name,
    output logic [127:0] product_description,
    output logic [7:0]   source_device_information,
    output logic         spd_update,
    output logic         checksum_error,
    output logic         spd_received
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_BODY,
        ST_SKIP
    } state_t;

    localparam logic [7:0] SPD_TYPE    = 8'h83;
    localparam logic [7:0] SPD_VERSION = 8'h01;
    localparam logic [7:0] SPD_LENGTH  = 8'h19;
    localparam logic [4:0] IDX_LAST    = 5'd30;
    localparam logic [4:0] IDX_PB25    = 5'd28;
    localparam logic [4:0] IDX_PB1     = 5'd4;

    localparam int GW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t              state_q, state_d;
    logic [4:0]          idx_q, idx_d;
    logic [7:0]          sum_q, sum_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [24:0][7:0]    shadow_q, shadow_d;
    logic [63:0]         vendor_q, vendor_d;
    logic [127:0]        product_q, product_d;
    logic [7:0]          sdi_q, sdi_d;
    logic                update_q, update_d;
    logic                cks_err_q, cks_err_d;
    logic                received_q, received_d;
    logic [4:0]          slot;

    // Shadow slot 0 holds PB1; PB0 and PB26/PB27 are never published.
    assign slot = idx_q - IDX_PB1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        gap_d      = gap_q;
        shadow_d   = shadow_q;
        vendor_d   = vendor_q;
        product_d  = product_q;
        sdi_d      = sdi_q;
        update_d   = 1'b0;
        cks_err_d  = 1'b0;
        received_d = received_q;

        if (in_valid && in_start) begin
            sum_d   = in_byte;
            idx_d   = 5'd1;
            gap_d   = '0;
            state_d = (in_byte == SPD_TYPE) ? ST_HEADER : ST_SKIP;
        end else if (in_valid) begin
            gap_d = '0;
            case (state_q)
                ST_HEADER: begin
                    sum_d = sum_q + in_byte;
                    idx_d = idx_q + 5'd1;
                    if ((idx_q == 5'd1 && in_byte != SPD_VERSION) ||
                        (idx_q == 5'd2 && in_byte != SPD_LENGTH)) begin
                        state_d = ST_SKIP;
                    end else if (idx_q == 5'd2) begin
                        state_d = ST_BODY;
                    end
                end
                ST_BODY: begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q <= IDX_PB25) begin
                        sum_d = sum_q + in_byte;
                    end
                    if (idx_q >= IDX_PB1 && idx_q <= IDX_PB25) begin
                        shadow_d[slot] = in_byte;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        sum_d   = '0;
                        if (sum_q == 8'h00) begin
                            for (int k = 0; k < 8; k++) begin
                                vendor_d[63 - 8*k -: 8] = shadow_q[k];
                            end
                            for (int k = 0; k < 16; k++) begin
                                product_d[127 - 8*k -: 8] = shadow_q[8 + k];
                            end
                            sdi_d      = shadow_q[24];
                            update_d   = 1'b1;
                            received_d = 1'b1;
                        end else begin
                            cks_err_d = 1'b1;
                        end
                    end
                end
                ST_SKIP: begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        sum_d   = '0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end else if (TIMEOUT > 0 && state_q != ST_IDLE) begin
            if (gap_q == GAP_LAST) begin
                state_d = ST_IDLE;
                idx_d   = '0;
                sum_d   = '0;
                gap_d   = '0;
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            sum_q      <= '0;
            gap_q      <= '0;
            shadow_q   <= '0;
            vendor_q   <= '0;
            product_q  <= '0;
            sdi_q      <= '0;
            update_q   <= 1'b0;
            cks_err_q  <= 1'b0;
            received_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            gap_q      <= gap_d;
            shadow_q   <= shadow_d;
            vendor_q   <= vendor_d;
            product_q  <= product_d;
            sdi_q      <= sdi_d;
            update_q   <= update_d;
            cks_err_q  <= cks_err_d;
            received_q <= received_d;
        end
    end

    assign vendor_name               = vendor_q;
    assign product_description       = product_q;
    assign source_device_information = sdi_q;
    assign spd_update                = update_q;
    assign checksum_error            = cks_err_q;
    assign spd_received              = received_q;

endmodule

// File: tb/tb_spd_info_frame_receiver.sv
// Bench for spd_info_frame_receiver: packet-level reference model feeds a scoreboard,
// an independent monitor checks every pulse against it.
module tb_spd_info_frame_receiver;

    localparam int TIMEOUT = 64;

    logic         clk_pixel = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_start;
    logic [7:0]   in_byte;
    logic [63:0]  vendor_name;
    logic [127:0] product_description;
    logic [7:0]   source_device_information;
    logic         spd_update;
    logic         checksum_error;
    logic         spd_received;

    always #5 clk_pixel = ~clk_pixel;

    spd_info_frame_receiver #(.TIMEOUT(TIMEOUT)) dut (
        .clk_pixel                 (clk_pixel),
        .reset_n                   (reset_n),
        .in_valid                  (in_valid),
        .in_start                  (in_start),
        .in_byte                   (in_byte),
        .vendor_name               (vendor_name),
        .product_description       (product_description),
        .source_device_information (source_device_information),
        .spd_update                (spd_update),
        .checksum_error            (checksum_error),
        .spd_received              (spd_received)
    );

    typedef struct {
        bit           is_upd;
        logic [63:0]  v;
        logic [127:0] p;
        logic [7:0]   s;
        bit           rcvd;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    logic [7:0]   pkt [31];
    logic [63:0]  m_v = '0;
    logic [127:0] m_p = '0;
    logic [7:0]   m_s = '0;
    bit           m_rcvd = 1'b0;

    always @(posedge clk_pixel) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk_pixel) begin : monitor
        exp_t e;
        if (spd_update === 1'b1 || checksum_error === 1'b1) begin
            check("pulse_exclusive", 128'(spd_update & checksum_error), 128'd0);
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: upd=%b err=%b at cycle %0d with nothing pending",
                         spd_update, checksum_error, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", 128'(spd_update), 128'(e.is_upd));
                check("pulse_cycle", 128'(cyc), 128'(e.cyc));
                check("vendor_name", 128'(vendor_name), 128'(e.v));
                check("product_description", product_description, e.p);
                check("source_device_information", 128'(source_device_information), 128'(e.s));
                check("spd_received", 128'(spd_received), 128'(e.rcvd));
            end
        end
    end

    task automatic drive(input bit v, input bit s, input logic [7:0] b);
        @(posedge clk_pixel);
        #1;
        in_valid = v;
        in_start = s;
        in_byte  = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom));
    endtask

    // Reference: a full 31-byte packet completes; SPD iff header matches; good iff bytes 0..28 sum to 0.
    task automatic expect_completion();
        logic [7:0] s;
        exp_t e;
        s = 8'h00;
        for (int i = 0; i < 29; i++) s = s + pkt[i];
        if (!(pkt[0] == 8'h83 && pkt[1] == 8'h01 && pkt[2] == 8'h19)) return;
        if (s == 8'h00) begin
            for (int k = 0; k < 8; k++)  m_v = {m_v[55:0], pkt[4 + k]};
            for (int k = 0; k < 16; k++) m_p = {m_p[119:0], pkt[12 + k]};
            m_s    = pkt[28];
            m_rcvd = 1'b1;
            e.is_upd = 1'b1;
        end else begin
            e.is_upd = 1'b0;
        end
        e.v    = m_v;
        e.p    = m_p;
        e.s    = m_s;
        e.rcvd = m_rcvd;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic send_pkt(input int n, input int gap_after, input int gap_len);
        bit aborted;
        aborted = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, i == 0, pkt[i]);
            if (i == 30 && !aborted) expect_completion();
            if (i == gap_after && i < n - 1 && gap_len > 0) begin
                idle(gap_len);
                if (TIMEOUT > 0 && gap_len >= TIMEOUT) aborted = 1'b1;
            end
        end
    endtask

    task automatic fix_sum();
        logic [7:0] s;
        pkt[3] = 8'h00;
        s = 8'h00;
        for (int i = 0; i < 29; i++) s = s + pkt[i];
        pkt[3] = 8'h00 - s;
    endtask

    task automatic mk_spd_random();
        pkt[0] = 8'h83;
        pkt[1] = 8'h01;
        pkt[2] = 8'h19;
        for (int i = 3; i < 31; i++) pkt[i] = 8'($urandom);
        fix_sum();
    endtask

    task automatic mk_spd_zero();
        pkt[0] = 8'h83;
        pkt[1] = 8'h01;
        pkt[2] = 8'h19;
        pkt[3] = 8'h63;
        for (int i = 4; i < 31; i++) pkt[i] = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vendor"}, 128'(vendor_name), 128'd0);
        check({tag, "_product"}, product_description, 128'd0);
        check({tag, "_sdi"}, 128'(source_device_information), 128'd0);
        check({tag, "_update"}, 128'(spd_update), 128'd0);
        check({tag, "_cks_err"}, 128'(checksum_error), 128'd0);
        check({tag, "_received"}, 128'(spd_received), 128'd0);
    endtask

    task automatic reset_dut(input string tag);
        @(posedge clk_pixel);
        #1;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_start = 1'b0;
        @(posedge clk_pixel);
        @(negedge clk_pixel);
        check_all_zero(tag);
        m_v    = '0;
        m_p    = '0;
        m_s    = '0;
        m_rcvd = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic drain();
        idle(3);
        check("scoreboard_drained", 128'(sb.size()), 128'd0);
        sb.delete();
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_start = 1'b0;
        in_byte  = 8'h00;
        repeat (3) @(posedge clk_pixel);
        @(negedge clk_pixel);
        check_all_zero("reset");
        reset_n = 1'b1;

        // All-zero payload frame.
        mk_spd_zero();
        send_pkt(31, -1, 0);
        drain();
        check("s1_received", 128'(spd_received), 128'd1);

        // HDMIUTIL vendor, SDI 0x01.
        mk_spd_zero();
        pkt[4] = 8'h48; pkt[5] = 8'h44; pkt[6] = 8'h4D; pkt[7]  = 8'h49;
        pkt[8] = 8'h55; pkt[9] = 8'h54; pkt[10] = 8'h49; pkt[11] = 8'h4C;
        pkt[28] = 8'h01;
        fix_sum();
        send_pkt(31, -1, 0);
        drain();
        check("s2_vendor_const", 128'(vendor_name), 128'(64'h48444D495554494C));
        check("s2_sdi_const", 128'(source_device_information), 128'h01);

        // Bad checksum: outputs must stay at HDMIUTIL.
        mk_spd_zero();
        pkt[3] = 8'h64;
        send_pkt(31, -1, 0);
        drain();
        check("s3_vendor_kept", 128'(vendor_name), 128'(64'h48444D495554494C));

        // AVI packet then an immediately following good SPD frame.
        for (int i = 0; i < 31; i++) pkt[i] = 8'($urandom);
        pkt[0] = 8'h82;
        send_pkt(31, -1, 0);
        mk_spd_random();
        send_pkt(31, -1, 0);
        drain();

        // Gaps: 10 and 63 survive, 64 aborts.
        mk_spd_random();
        send_pkt(31, 12, 10);
        mk_spd_random();
        send_pkt(31, 20, 63);
        mk_spd_random();
        send_pkt(31, 17, 64);
        drain();

        // New start mid-body drops the old packet.
        mk_spd_random();
        send_pkt(16, -1, 0);
        mk_spd_random();
        send_pkt(31, -1, 0);
        drain();

        // Reset mid-body after a good frame, then recover.
        mk_spd_random();
        send_pkt(15, -1, 0);
        reset_dut("s6_reset");
        mk_spd_random();
        send_pkt(31, -1, 0);
        drain();
        check("s6_received", 128'(spd_received), 128'd1);

        for (int t = 0; t < 80; t++) begin
            int kind, n, gap_after, gap_len, pick;
            kind = $urandom_range(0, 9);
            n = 31;
            gap_after = -1;
            gap_len = 0;
            mk_spd_random();
            if (kind == 5) begin
                pkt[$urandom_range(3, 28)] += 8'($urandom_range(1, 255));
            end else if (kind == 6) begin
                pick = $urandom_range(0, 2);
                pkt[pick] ^= 8'($urandom_range(1, 255));
            end else if (kind == 7) begin
                n = $urandom_range(1, 30);
            end
            if ($urandom_range(0, 2) == 0) begin
                gap_after = $urandom_range(0, 29);
                pick = $urandom_range(0, 3);
                case (pick)
                    0: gap_len = $urandom_range(1, 20);
                    1: gap_len = 63;
                    2: gap_len = 64;
                    default: gap_len = $urandom_range(65, 75);
                endcase
            end
            send_pkt(n, gap_after, gap_len);
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < $urandom_range(1, 4); j++) drive(1'b1, 1'b0, 8'($urandom));
            end
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
        end
        drain();
        check("final_vendor", 128'(vendor_name), 128'(m_v));
        check("final_product", product_description, m_p);
        check("final_sdi", 128'(source_device_information), 128'(m_s));
        check("final_received", 128'(spd_received), 128'(m_rcvd));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spd_info_frame_receiver.md
Name: spd_info_frame_receiver

Overview:
- Sink-side counterpart of the SPD InfoFrame generator. It consumes a decoded HDMI data-island packet as a byte stream: HB0..HB2, then PB0..PB27.
- It recognises Source Product Description InfoFrames (type 0x83, version 0x01, length 25) and verifies the checksum.
- Vendor name, product description and source device information are published only from frames that pass the checksum.
- It sits after the data-island TERC4 decode / packet byte deserialiser in the receive path, in the pixel clock domain.

Parameters:
- TIMEOUT, 64, max consecutive cycles without in_valid inside a packet before the packet is aborted; 0 disables the timeout.

Ports:
- clk_pixel  input  1  pixel clock; all logic on rising edge.
- reset_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_byte is valid this cycle.
- in_start  input  1  qualifies in_valid; marks in_byte as HB0 of a new packet.
- in_byte  input  8  packet byte; order HB0, HB1, HB2, PB0..PB27 (31 bytes).
- vendor_name  output  64  PB1 in [63:56] down to PB8 in [7:0].
- product_description  output  128  PB9 in [127:120] down to PB24 in [7:0].
- source_device_information  output  8  PB25.
- spd_update  output  1  one-cycle pulse: the outputs above were just refreshed.
- checksum_error  output  1  one-cycle pulse: SPD frame rejected on checksum.
- spd_received  output  1  sticky; set on first good frame, cleared only by reset.

Behaviour:
- Reset (reset_n low at an edge):
  - state IDLE; byte index, checksum accumulator and gap counter cleared.
  - All outputs 0, shadow buffer 0.
- States:
  - IDLE: ignores in_valid without in_start. On in_valid&in_start, it captures HB0, sets sum=in_byte and index=1, then goes to HEADER.
  - HEADER: checks HB0==0x83 (on entry), HB1==0x01 and HB2==0x19 as each is accepted.
    - Any mismatch goes to SKIP.
    - After HB2 matches, goes to BODY.
  - BODY: accepts PB0..PB27 into the shadow buffer.
    - sum += byte for PB0..PB25 only; PB26 and PB27 are accepted but excluded from the checksum.
  - SKIP: discards bytes until index reaches 30, then goes to IDLE. Non-SPD packets are silently ignored, with no pulses.
- Byte index increments only on in_valid; in_valid low stalls with no state change.
- Checksum: 8-bit modulo-256 sum of HB0..HB2 and PB0..PB25.
- Completion (the cycle the byte at index 30, PB27, is accepted, cycle N):
  - sum==0: at N+1, outputs are loaded from the shadow buffer, spd_update=1 for one cycle, spd_received=1.
  - sum!=0: at N+1, checksum_error=1 for one cycle; outputs unchanged.
  - State returns to IDLE at N+1.
- Outputs never show partially received data; the shadow buffer is committed atomically.
- in_valid&in_start in any non-IDLE state aborts the current packet without pulses. That byte is treated as HB0 of a new packet, following the same path as IDLE, in the same cycle.
- Timeout (TIMEOUT>0): a gap counter counts cycles with in_valid low while not IDLE and resets on in_valid. When it reaches TIMEOUT, the packet aborts to IDLE with no pulses and outputs unchanged.
- The byte index saturates logic-wise at 30; excess bytes beyond 31 are impossible because completion forces IDLE.
- Back-to-back packets: in_start on cycle N+1 after completion is accepted, because the state is IDLE at N+1.
- Payload bytes are output raw, with no character translation.
- spd_update and checksum_error are never asserted together.

Test Plan:
1. Reset, then stream 83 01 19 63 followed by 27 bytes 00, in_valid continuous -> spd_update pulses 1 cycle after the last byte; all fields 0; spd_received=1.
2. Vendor "HDMIUTIL" (48 44 4D 49 55 54 49 4C), product bytes 0, SDI=0x01, PB0 set so the sum is 0 -> vendor_name=0x48444D495554494C; source_device_information=0x01; spd_update pulses.
3. Frame from scenario 1 with PB0=0x64 -> checksum_error pulses once; outputs unchanged; spd_received unchanged.
4. Packet with HB0=0x82 (AVI), 31 bytes -> no pulses, outputs unchanged; an immediately following good SPD frame is accepted.
5. Good frame with in_valid deasserted 10 cycles mid-BODY (TIMEOUT=64) -> accepted. The same frame with a 64-cycle gap -> aborted, no pulses. A new in_start after index 15 of a packet -> the old packet is dropped and the new frame completes normally.
6. Assert reset_n low mid-BODY after a previous good frame -> all outputs 0 and spd_received=0 next cycle; the next good frame updates normally.
